video_timing_tpg: RTL and testbench
===================================

Name: video_timing_tpg

Overview:
- Parametrised video timing generator with a built-in, run-time selectable test-pattern generator.
- Successor to the fixed 640x480 generator that feeds the DVI encoder. All timing is set by parameters, sync polarity is configurable, and there are four pattern modes, frame-synchronous mode switching and start-of-frame/line strobes.
- Sits in the pixel clock domain, directly upstream of the VGA-to-DVI encoder.

Parameters:
- p_h_active, 640, active pixels per line
- p_h_fp, 16, horizontal front porch (clocks)
- p_h_sync, 96, horizontal sync width (clocks)
- p_h_bp, 48, horizontal back porch (clocks)
- p_v_active, 480, active lines per frame
- p_v_fp, 10, vertical front porch (lines)
- p_v_sync, 2, vertical sync width (lines)
- p_v_bp, 33, vertical back porch (lines)
- p_hsync_pol, 0, hsync asserted level (0 = active-low)
- p_vsync_pol, 0, vsync asserted level
- p_color_bits, 8, bits per colour channel (≥4)
- p_check_log2, 5, checkerboard square size is 2^p_check_log2 pixels

Ports:
- i_clk_pixel  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_mode  in  2  pattern select: 0 = bars, 1 = checker, 2 = gradient, 3 = solid
- i_solid  in  3×p_color_bits  colour used for mode 3
- o_hsync  out  1  horizontal sync, polarity per p_hsync_pol
- o_vsync  out  1  vertical sync, polarity per p_vsync_pol
- o_data_en  out  1  high during active video
- o_data  out  3×p_color_bits  pixel colour, index 0 = R, 1 = G, 2 = B
- o_x_pos  out  clog2(H_TOTAL)  horizontal counter, registered
- o_y_pos  out  clog2(V_TOTAL)  vertical counter, registered
- o_sof  out  1  one-clock pulse marking the first active pixel of a frame
- o_sol  out  1  one-clock pulse marking the first active pixel of each active line

Behaviour:
- Derived constants: H_TOTAL = sum of the four h parameters; V_TOTAL = sum of the four v parameters.
- Interface:
  - Single clock, i_clk_pixel.
  - i_rst_n is asynchronous and active-low.
  - All outputs are registered.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; v_cnt wraps 0 after V_TOTAL-1.
  - Both counters wrap in the same clock at the frame end (h = H_TOTAL-1, v = V_TOTAL-1).
- Decode, from the current counter values:
  - active = (h_cnt < p_h_active) && (v_cnt < p_v_active)
  - hs_on = h_cnt in [p_h_active+p_h_fp, p_h_active+p_h_fp+p_h_sync)
  - vs_on = v_cnt in [p_v_active+p_v_fp, p_v_active+p_v_fp+p_v_sync); vsync changes together with h_cnt = 0.
- Latency:
  - Every output reflects the counter state of the previous clock (1-cycle latency, uniform across all outputs).
  - o_data is forced to 0 whenever o_data_en = 0.
- Strobes:
  - o_sof = 1 for the output cycle of counter (0,0).
  - o_sol = 1 for the output cycle of h_cnt = 0 on an active line.
- Mode latch: i_mode is sampled into mode_q only when the counter is (0,0), so the pattern never changes mid-frame. i_solid is sampled at the same instant.
- Patterns (x = h_cnt, y = v_cnt; N = p_color_bits; F = all ones; ½ = MSB only):
  - Mode 0, bars: 8 equal bars with boundaries at k*p_h_active/8, resolved at elaboration and selected by comparators. Bar order is white, yellow, cyan, green, magenta, red, blue, black.
  - Mode 1, checker: white when x[p_check_log2] ^ y[p_check_log2], else black.
  - Mode 2, gradient: R = x[N-1:0], G = y[N-1:0], B = (x^y)[N-1:0]. Values wrap naturally.
  - Mode 3, solid: latched i_solid.
- Reset, asynchronous assert and synchronous-release behaviour:
  - Counters 0, mode_q 0, latched solid 0.
  - o_hsync = !p_hsync_pol, o_vsync = !p_vsync_pol.
  - o_data_en 0, o_data 0, o_x_pos 0, o_y_pos 0, o_sof 0, o_sol 0.
  - First clock after release: outputs reflect (0,0), so o_data_en = 1 and o_sof = 1.
- Reset mid-frame: counters restart at (0,0). No partial-line recovery.
- Elaboration check: reject p_h_active < 8, any zero sync width, or p_color_bits < 4.

Optional Feature:
- Macro: VTG_SCROLL_EN.
- When defined:
  - An internal frame counter (width N) increments at each frame wrap and resets to 0.
  - Mode 1 uses x+frame and mode 2 uses x+frame in place of x, giving horizontal scroll of 1 pixel per frame.
  - Adds output o_frame_cnt (N bits), registered.
- When undefined: no frame counter, no o_frame_cnt port, patterns are static.

Test Plan:
- Reset hold, then release with defaults -> o_hsync = 1, o_vsync = 1, o_data_en = 0 while in reset. First clock after release: o_data_en = 1, o_sof = 1, x = 0, y = 0.
- Free run one frame -> exactly 420000 clocks between o_sof pulses; hsync low 96 clocks starting at h = 656; vsync low 1600 clocks starting at v = 490, h = 0; 480 o_sol pulses per frame.
- Mode 0 -> pixel x = 0 is white (FF,FF,FF), x = 80 is yellow (FF,FF,00), x = 639 is black; o_data = 0 at x = 640 (blanking).
- Mode switch 0→2 asserted at y = 100 -> bars continue until frame end; gradient from the next o_sof; pixel (3,5) = (03,05,06).
- Mode 3 with i_solid = (12,34,56), i_solid changed mid-frame -> old colour held until next frame; new colour from the next o_sof.
- Reset asserted at (300,200) -> outputs return to reset values immediately (async); after release, o_sof fires on the first clock. With VTG_SCROLL_EN: o_frame_cnt returns to 0 and checker phase shifts by 1 pixel per frame.

Source files
------------

// File: rtl/video_timing_tpg.sv
// Parametrised video timing generator with a run-time selectable test-pattern source.
// Define VTG_SCROLL_EN to add a per-frame horizontal scroll and the o_frame_cnt output.
module video_timing_tpg #(
    parameter int p_h_active   = 640,
    parameter int p_h_fp       = 16,
    parameter int p_h_sync     = 96,
    parameter int p_h_bp       = 48,
    parameter int p_v_active   = 480,
    parameter int p_v_fp       = 10,
    parameter int p_v_sync     = 2,
    parameter int p_v_bp       = 33,
    parameter int p_hsync_pol  = 0,
    parameter int p_vsync_pol  = 0,
    parameter int p_color_bits = 8,
    parameter int p_check_log2 = 5
) (
    input  logic                                                       i_clk_pixel,
    input  logic                                                       i_rst_n,
    input  logic [1:0]                                                 i_mode,
    input  logic [3*p_color_bits-1:0]                                  i_solid,
    output logic                                                       o_hsync,
    output logic                                                       o_vsync,
    output logic                                                       o_data_en,
    output logic [3*p_color_bits-1:0]                                  o_data,
    output logic [$clog2(p_h_active+p_h_fp+p_h_sync+p_h_bp)-1:0]       o_x_pos,
    output logic [$clog2(p_v_active+p_v_fp+p_v_sync+p_v_bp)-1:0]       o_y_pos,
    output logic                                                       o_sof,
    output logic                                                       o_sol
`ifdef VTG_SCROLL_EN
    ,
    output logic [p_color_bits-1:0]                                    o_frame_cnt
`endif
);

    localparam int H_TOTAL = p_h_active + p_h_fp + p_h_sync + p_h_bp;
    localparam int V_TOTAL = p_v_active + p_v_fp + p_v_sync + p_v_bp;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int N       = p_color_bits;
    localparam int HE      = HW + 1;
    localparam int VE      = VW + 1;
    localparam int XW      = (N > p_check_log2 + 1) ? N : p_check_log2 + 1;
    localparam int HS_BEG  = p_h_active + p_h_fp;
    localparam int HS_END  = HS_BEG + p_h_sync;
    localparam int VS_BEG  = p_v_active + p_v_fp;
    localparam int VS_END  = VS_BEG + p_v_sync;
    localparam logic HS_ASSERT = (p_hsync_pol != 0);
    localparam logic VS_ASSERT = (p_vsync_pol != 0);

    generate
        if (p_h_active < 8 || p_h_sync == 0 || p_v_sync == 0 || p_color_bits < 4) begin : g_bad_cfg
            $error("video_timing_tpg: illegal parameter set");
        end
    endgenerate

    logic [HW-1:0]  h_cnt_r;
    logic [VW-1:0]  v_cnt_r;
    logic [1:0]     mode_r;
    logic [3*N-1:0] solid_r;
    logic [HE-1:0]  h_ext_s;
    logic [VE-1:0]  v_ext_s;
    logic           h_last_s;
    logic           v_last_s;
    logic           origin_s;
    logic           active_s;
    logic           v_active_s;
    logic           hs_on_s;
    logic           vs_on_s;
    logic [1:0]     mode_eff_s;
    logic [3*N-1:0] solid_eff_s;
    logic [XW-1:0]  x_eff_s;
    logic [XW-1:0]  y_eff_s;
    logic [2:0]     bar_idx_s;
    logic [2:0]     bar_rgb_s;
    logic [3*N-1:0] pix_s;
`ifdef VTG_SCROLL_EN
    logic [N-1:0]   frame_r;
`endif

    assign h_ext_s    = {1'b0, h_cnt_r};
    assign v_ext_s    = {1'b0, v_cnt_r};
    assign h_last_s   = (h_ext_s == HE'(H_TOTAL - 1));
    assign v_last_s   = (v_ext_s == VE'(V_TOTAL - 1));
    assign origin_s   = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
    assign v_active_s = (v_ext_s < VE'(p_v_active));
    assign active_s   = (h_ext_s < HE'(p_h_active)) && v_active_s;
    assign hs_on_s    = (h_ext_s >= HE'(HS_BEG)) && (h_ext_s < HE'(HS_END));
    assign vs_on_s    = (v_ext_s >= VE'(VS_BEG)) && (v_ext_s < VE'(VS_END));

    // The frame that starts at (0,0) already uses the mode and colour presented at (0,0).
    assign mode_eff_s  = origin_s ? i_mode  : mode_r;
    assign solid_eff_s = origin_s ? i_solid : solid_r;

`ifdef VTG_SCROLL_EN
    assign x_eff_s = XW'(h_cnt_r) + XW'(frame_r);
`else
    assign x_eff_s = XW'(h_cnt_r);
`endif
    assign y_eff_s = XW'(v_cnt_r);

    // Raster counters, frame-synchronous pattern latch and optional frame counter.
    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= {VW{1'b0}};
            mode_r  <= 2'd0;
            solid_r <= {3*N{1'b0}};
`ifdef VTG_SCROLL_EN
            frame_r <= {N{1'b0}};
`endif
        end else begin
            if (origin_s) begin
                mode_r  <= i_mode;
                solid_r <= i_solid;
            end
            if (h_last_s) begin
                h_cnt_r <= {HW{1'b0}};
                if (v_last_s) begin
                    v_cnt_r <= {VW{1'b0}};
`ifdef VTG_SCROLL_EN
                    frame_r <= frame_r + {{(N-1){1'b0}}, 1'b1};
`endif
                end else begin
                    v_cnt_r <= v_cnt_r + {{(VW-1){1'b0}}, 1'b1};
                end
            end else begin
                h_cnt_r <= h_cnt_r + {{(HW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Colour-bar index from elaboration-time boundaries; colour bits are {R,G,B}.
    always_comb begin
        bar_idx_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_ext_s >= HE'(k * p_h_active / 8)) begin
                bar_idx_s = bar_idx_s + 3'd1;
            end else begin
                bar_idx_s = bar_idx_s;
            end
        end
        case (bar_idx_s)
            3'd0:    bar_rgb_s = 3'b111;
            3'd1:    bar_rgb_s = 3'b110;
            3'd2:    bar_rgb_s = 3'b011;
            3'd3:    bar_rgb_s = 3'b010;
            3'd4:    bar_rgb_s = 3'b101;
            3'd5:    bar_rgb_s = 3'b100;
            3'd6:    bar_rgb_s = 3'b001;
            default: bar_rgb_s = 3'b000;
        endcase
    end

    // Pattern mux; pixel word is packed {B,G,R} so channel 0 is red.
    always_comb begin
        pix_s = {3*N{1'b0}};
        case (mode_eff_s)
            2'd0: pix_s = {{N{bar_rgb_s[0]}}, {N{bar_rgb_s[1]}}, {N{bar_rgb_s[2]}}};
            2'd1: pix_s = (x_eff_s[p_check_log2] ^ y_eff_s[p_check_log2]) ? {3*N{1'b1}} : {3*N{1'b0}};
            2'd2: pix_s = {x_eff_s[N-1:0] ^ y_eff_s[N-1:0], y_eff_s[N-1:0], x_eff_s[N-1:0]};
            2'd3: pix_s = solid_eff_s;
            default: pix_s = {3*N{1'b0}};
        endcase
    end

    // Output stage: every output shows the counter state of the previous clock.
    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hsync     <= ~HS_ASSERT;
            o_vsync     <= ~VS_ASSERT;
            o_data_en   <= 1'b0;
            o_data      <= {3*N{1'b0}};
            o_x_pos     <= {HW{1'b0}};
            o_y_pos     <= {VW{1'b0}};
            o_sof       <= 1'b0;
            o_sol       <= 1'b0;
`ifdef VTG_SCROLL_EN
            o_frame_cnt <= {N{1'b0}};
`endif
        end else begin
            o_hsync     <= hs_on_s ? HS_ASSERT : ~HS_ASSERT;
            o_vsync     <= vs_on_s ? VS_ASSERT : ~VS_ASSERT;
            o_data_en   <= active_s;
            o_data      <= active_s ? pix_s : {3*N{1'b0}};
            o_x_pos     <= h_cnt_r;
            o_y_pos     <= v_cnt_r;
            o_sof       <= origin_s;
            o_sol       <= (h_cnt_r == {HW{1'b0}}) && v_active_s;
`ifdef VTG_SCROLL_EN
            o_frame_cnt <= frame_r;
`endif
        end
    end

endmodule

// File: tb/tb_video_timing_tpg.sv
// Scoreboard bench for video_timing_tpg on a reduced 24x13 raster.
// Each cycle's expected outputs are queued at drive time and popped one clock later.
module tb_video_timing_tpg;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int CL = 2;
    localparam logic HSP = 1'b0;
    localparam logic VSP = 1'b1;
    localparam int XWD = $clog2(HT);
    localparam int YWD = $clog2(VT);
    localparam logic [2:0] BAR_TAB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                           3'b101, 3'b100, 3'b001, 3'b000};

    typedef struct packed {
        logic           hs;
        logic           vs;
        logic           de;
        logic [23:0]    data;
        logic [XWD-1:0] x;
        logic [YWD-1:0] y;
        logic           sof;
        logic           sol;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     mode;
    logic [23:0]    solid;
    logic           o_hsync, o_vsync, o_data_en, o_sof, o_sol;
    logic [23:0]    o_data;
    logic [XWD-1:0] o_x_pos;
    logic [YWD-1:0] o_y_pos;
`ifdef VTG_SCROLL_EN
    logic [7:0]     o_frame_cnt;
    logic [7:0]     fq [$];
`endif

    exp_t        q [$];
    int          vec = 0;
    int          miss = 0;
    int          mh = 0, mv = 0, mf = 0;
    logic [1:0]  mq = 2'd0;
    logic [23:0] sq = 24'h0;

    video_timing_tpg #(
        .p_h_active(HA), .p_h_fp(HF), .p_h_sync(HS), .p_h_bp(HB),
        .p_v_active(VA), .p_v_fp(VF), .p_v_sync(VS), .p_v_bp(VB),
        .p_hsync_pol(0), .p_vsync_pol(1), .p_color_bits(8), .p_check_log2(CL)
    ) dut (
        .i_clk_pixel(clk), .i_rst_n(rst_n), .i_mode(mode), .i_solid(solid),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_data_en(o_data_en), .o_data(o_data),
        .o_x_pos(o_x_pos), .o_y_pos(o_y_pos), .o_sof(o_sof), .o_sol(o_sol)
`ifdef VTG_SCROLL_EN
        , .o_frame_cnt(o_frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t rst_exp();
        exp_t e;
        e = '0;
        e.hs = ~HSP;
        e.vs = ~VSP;
        return e;
    endfunction

    function automatic exp_t model(int h, int v, logic [1:0] m, logic [23:0] s, int f);
        exp_t e;
        logic [7:0] r, g, b;
        logic [2:0] c;
        int xs;
        xs = h + f;
        r = 8'h00; g = 8'h00; b = 8'h00;
        e.hs  = (h >= HA + HF && h < HA + HF + HS) ? HSP : ~HSP;
        e.vs  = (v >= VA + VF && v < VA + VF + VS) ? VSP : ~VSP;
        e.de  = (h < HA) && (v < VA);
        e.x   = XWD'(h);
        e.y   = YWD'(v);
        e.sof = (h == 0) && (v == 0);
        e.sol = (h == 0) && (v < VA);
        case (m)
            2'd0: begin
                if (h < HA) c = BAR_TAB[(h * 8) / HA];
                else        c = 3'b000;
                r = {8{c[2]}}; g = {8{c[1]}}; b = {8{c[0]}};
            end
            2'd1: if ((((xs >> CL) ^ (v >> CL)) & 1) != 0) begin r = 8'hFF; g = 8'hFF; b = 8'hFF; end
            2'd2: begin r = 8'(xs); g = 8'(v); b = 8'(xs ^ v); end
            default: {b, g, r} = s;
        endcase
        e.data = e.de ? {b, g, r} : 24'h0;
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_vec();
        exp_t a, e;
        a = {o_hsync, o_vsync, o_data_en, o_data, o_x_pos, o_y_pos, o_sof, o_sol};
        if (q.size() == 0) begin
            vec++; miss++;
            $error("FAIL scoreboard: observed %h expected <queued entry>", a);
        end else begin
            e = q.pop_front();
            vec++;
            assert (a === e) else begin
                miss++;
                $error("FAIL cycle_vec %0d: observed %h expected %h (hs vs de data x y sof sol)", vec, a, e);
            end
        end
`ifdef VTG_SCROLL_EN
        if (fq.size() != 0) chk("frame_cnt", 32'(o_frame_cnt), 32'(fq.pop_front()));
`endif
    endtask

    // Queue the expected result of the coming clock, advance the model, then compare.
    task automatic step();
        exp_t e;
        int f;
        f = 0;
`ifdef VTG_SCROLL_EN
        f = mf;
`endif
        if (rst_n) begin
            if (mh == 0 && mv == 0) begin mq = mode; sq = solid; end
            e = model(mh, mv, mq, sq, f);
            if (mh == HT - 1) begin
                mh = 0;
                if (mv == VT - 1) begin mv = 0; mf = (mf + 1) % 256; end
                else mv++;
            end else mh++;
        end else begin
            e = rst_exp();
            f = 0;
        end
        q.push_back(e);
`ifdef VTG_SCROLL_EN
        fq.push_back(8'(f));
`endif
        @(posedge clk);
        #1;
        check_vec();
    endtask

    task automatic run_until(int x, int y);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(o_x_pos == XWD'(x) && o_y_pos == YWD'(y)) && n < 2 * HT * VT);
        if (!(o_x_pos == XWD'(x) && o_y_pos == YWD'(y))) begin
            vec++; miss++;
            $error("FAIL run_until: observed (%0d,%0d) expected (%0d,%0d) within %0d clocks",
                   o_x_pos, o_y_pos, x, y, 2 * HT * VT);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mf = 0; mq = 2'd0; sq = 24'h0;
    endtask

    initial begin
        int period, sols, hs_low, vs_act;
        bit got;
        rst_n = 1'b1; mode = 2'd0; solid = 24'h0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_hsync", 32'(o_hsync), 32'd1);
        chk("rst_vsync", 32'(o_vsync), 32'd0);
        chk("rst_de", 32'(o_data_en), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rel_de", 32'(o_data_en), 32'd1);
        chk("rel_sof", 32'(o_sof), 32'd1);
        chk("rel_x", 32'(o_x_pos), 32'd0);
        chk("rel_y", 32'(o_y_pos), 32'd0);

        // Free-run one frame in bar mode, measuring strobes and sync widths.
        period = 0; sols = 1; hs_low = 0; vs_act = 0; got = 1'b0;
        for (int i = 1; i <= 2 * HT * VT && !got; i++) begin
            step();
            if (o_sof) begin
                got = 1'b1;
                period = i;
            end else begin
                sols   += int'(o_sol);
                hs_low += int'(!o_hsync);
                vs_act += int'(o_vsync);
                if (o_y_pos == YWD'(1)) begin
                    if (o_x_pos == XWD'(0))  chk("bar_white",  32'(o_data), 32'h00FFFFFF);
                    if (o_x_pos == XWD'(2))  chk("bar_yellow", 32'(o_data), 32'h0000FFFF);
                    if (o_x_pos == XWD'(15)) chk("bar_black",  32'(o_data), 32'h00000000);
                    if (o_x_pos == XWD'(16)) chk("blank_zero", 32'(o_data), 32'h00000000);
                end
            end
        end
        chk("frame_len", 32'(period), 32'(HT * VT));
        chk("sol_count", 32'(sols), 32'(VA));
        chk("hsync_low", 32'(hs_low), 32'(HS * VT));
        chk("vsync_on", 32'(vs_act), 32'(VS * HT));

        // Switch to gradient mid-frame: bars hold until the next frame.
        run_until(0, 3);
        mode = 2'd2;
        run_until(0, 4);
        chk("bars_hold", 32'(o_data), 32'h00FFFFFF);
        run_until(0, 0);
        chk("grad_sof", 32'(o_sof), 32'd1);
`ifndef VTG_SCROLL_EN
        run_until(3, 5);
        chk("grad_3_5", 32'(o_data), 32'h00060503);
`endif

        // Solid colour latched per frame.
        mode = 2'd3;
        solid = 24'h563412;
        run_until(0, 0);
        chk("solid_a", 32'(o_data), 32'h00563412);
        run_until(5, 2);
        solid = 24'hABCDEF;
        run_until(7, 6);
        chk("solid_hold", 32'(o_data), 32'h00563412);
        run_until(0, 0);
        chk("solid_b", 32'(o_data), 32'h00ABCDEF);

        // Checkerboard.
        mode = 2'd1;
        run_until(0, 0);
`ifndef VTG_SCROLL_EN
        run_until(4, 0);
        chk("chk_4_0", 32'(o_data), 32'h00FFFFFF);
        run_until(0, 4);
        chk("chk_0_4", 32'(o_data), 32'h00FFFFFF);
        run_until(4, 4);
        chk("chk_4_4", 32'(o_data), 32'h00000000);
`endif

        // Asynchronous reset mid-frame.
        run_until(10, 5);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_hsync", 32'(o_hsync), 32'd1);
        chk("async_vsync", 32'(o_vsync), 32'd0);
        chk("async_de", 32'(o_data_en), 32'd0);
        chk("async_x", 32'(o_x_pos), 32'd0);
        chk("async_y", 32'(o_y_pos), 32'd0);
        chk("async_data", 32'(o_data), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("rerel_sof", 32'(o_sof), 32'd1);
        chk("rerel_de", 32'(o_data_en), 32'd1);
        run_until(0, 0);
        run_until(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
